conv_weight_bias_loader: RTL and testbench
==========================================

Name: conv_weight_bias_loader

Overview:
- Sequential bulk loader that copies one layer's signed 8-bit weights and biases from a byte-wide request/response memory into local register arrays.
- Sits between the weight backing memory and a convolution engine, which reads the arrays after `done`.
- Issues one read at a time and blocks on each response, so it works with any memory latency of 1 or more cycles.

Parameters:
- W_COUNT, 756: number of weight bytes, must be ≥1.
- B_COUNT, 28: number of bias bytes, must be ≥1.
- W_BASE, 0: byte address of weight[0] in memory.
- B_BASE, W_COUNT: byte address of bias[0]; biases follow the weights contiguously.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request.
- done  out  1  high once all words are stored; held until the next accepted start or reset.
- busy  out  1  high while a load is in progress.
- mem_req_valid  out  1  one-cycle read request strobe.
- mem_req_write  out  1  constant 0; the loader never writes.
- mem_req_addr  out  32  byte address, valid while mem_req_valid is high.
- mem_resp_valid  in  1  response strobe, one per request.
- mem_resp_data  in  8  read data, valid with mem_resp_valid.
- w_rd_addr  in  $clog2(W_COUNT)  weight readback index.
- w_rd_data  out  8  signed weight_mem[w_rd_addr]; combinational.
- b_rd_addr  in  $clog2(B_COUNT)  bias readback index.
- b_rd_data  out  8  signed bias_mem[b_rd_addr]; combinational.

Behaviour:
- Storage:
  - weight_mem[0:W_COUNT-1], signed 8-bit.
  - bias_mem[0:B_COUNT-1], signed 8-bit.
  - Both are hierarchically visible by these names.
  - Neither array is cleared by reset.
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; done=0, busy=0, mem_req_valid=0, mem_req_addr=0, index counter=0.
  - Reset mid-load aborts the load immediately. Array contents are then partial and undefined.
- FSM states: IDLE, W_REQ, W_WAIT, B_REQ, B_WAIT, DONE.
  - IDLE: on start=1, clear the index, set done=0, go to W_REQ.
  - W_REQ: assert mem_req_valid for exactly one cycle with mem_req_addr=W_BASE+idx; go to W_WAIT.
  - W_WAIT: on mem_resp_valid, store weight_mem[idx]=mem_resp_data.
    - If idx==W_COUNT-1: clear idx and go to B_REQ.
    - Else: idx++ and go to W_REQ.
  - B_REQ: one-cycle request with addr=B_BASE+idx; go to B_WAIT.
  - B_WAIT: on mem_resp_valid, store bias_mem[idx].
    - If idx==B_COUNT-1: go to DONE.
    - Else: idx++ and go to B_REQ.
  - DONE: done=1, busy=0. start=1 restarts the load (done drops the next cycle, goes to W_REQ).
- Outputs:
  - busy=1 in states W_REQ through B_WAIT.
  - done is registered.
  - mem_req_valid is registered or decoded from state; it is high only in W_REQ and B_REQ.
  - Exactly one request is outstanding at any time.
- Ignored inputs:
  - start is ignored while busy.
  - mem_resp_valid outside W_WAIT/B_WAIT is ignored and stores nothing.
- Timing with a 1-cycle-latency memory (request at edge N, response visible at edge N+1):
  - 2 cycles per word.
  - done rises 2*(W_COUNT+B_COUNT)+1 cycles after the start edge (1569 with defaults).
- Data is stored unchanged; the 8-bit pattern is reinterpreted as two's complement.
- Addresses are zero-extended to 32 bits; they do not wrap.

Test Plan:
- Memory mem[a]=a[7:0] for a<784, 1-cycle latency; reset, pulse start:
  - done rises after 1569 cycles.
  - weight_mem[5]=5, weight_mem[255]=-1, weight_mem[755]=0xF3 (-13).
  - bias_mem[0]=0x F4 (-12), bias_mem[27]=0x0F.
- Request trace check: 784 mem_req_valid pulses; addresses 0..783 in order; mem_req_write always 0; no second request before each response.
- Memory latency 3 cycles: identical array contents to the previous case; done delayed to 4*784+1 cycles.
- start pulsed again at cycle 100 of a load: no effect, load completes normally. After done, start with new memory contents: done drops, arrays are reloaded, done rises again.
- rst asserted mid-bias phase: next cycle done=0, busy=0, no requests. A subsequent start completes a full correct load.
- Spurious mem_resp_valid in IDLE with data 0x7F: weight_mem[0] is unchanged; readback via w_rd_addr and b_rd_addr matches the stored arrays.

Source files
------------

// File: rtl/conv_weight_bias_loader_if.sv
// Byte-wide request/response memory port used by the weight/bias loader.
// master = loader side, slave = memory side.
interface conv_weight_bias_loader_if;
   logic        mem_req_valid;
   logic        mem_req_write;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [7:0]  mem_resp_data;

   modport master (
      output mem_req_valid, mem_req_write, mem_req_addr,
      input  mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_write, mem_req_addr,
      output mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/conv_weight_bias_loader.sv
// Copies one layer's signed 8-bit weights then biases from a blocking byte memory
// into local arrays, one outstanding read at a time; done stays up until the next start.
module conv_weight_bias_loader #(
   parameter int W_COUNT = 756,
   parameter int B_COUNT = 28,
   parameter int W_BASE  = 0,
   parameter int B_BASE  = W_COUNT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        done,
   output logic                        busy,
   conv_weight_bias_loader_if.master   mem,
   input  logic [((W_COUNT > 1) ? $clog2(W_COUNT) : 1)-1:0] w_rd_addr,
   output logic signed [7:0]           w_rd_data,
   input  logic [((B_COUNT > 1) ? $clog2(B_COUNT) : 1)-1:0] b_rd_addr,
   output logic signed [7:0]           b_rd_data
);

   localparam int WA   = (W_COUNT > 1) ? $clog2(W_COUNT) : 1;
   localparam int BA   = (B_COUNT > 1) ? $clog2(B_COUNT) : 1;
   localparam int MAXC = (W_COUNT > B_COUNT) ? W_COUNT : B_COUNT;
   localparam int IW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [IW-1:0] W_LAST = IW'(W_COUNT - 1);
   localparam logic [IW-1:0] B_LAST = IW'(B_COUNT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_W_REQ, S_W_WAIT, S_B_REQ, S_B_WAIT, S_DONE
   } state_t;

   state_t         state, nxt;
   logic [IW-1:0]  idx;
   logic           w_last, b_last, accept;

   logic signed [7:0] weight_mem [0:W_COUNT-1];
   logic signed [7:0] bias_mem   [0:B_COUNT-1];

   assign w_last = (idx == W_LAST);
   assign b_last = (idx == B_LAST);
   assign accept = start && (state == S_IDLE || state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   if (start) nxt = S_W_REQ;
         S_W_REQ:  nxt = S_W_WAIT;
         S_W_WAIT: if (mem.mem_resp_valid) nxt = w_last ? S_B_REQ : S_W_REQ;
         S_B_REQ:  nxt = S_B_WAIT;
         S_B_WAIT: if (mem.mem_resp_valid) nxt = b_last ? S_DONE : S_B_REQ;
         S_DONE:   if (start) nxt = S_W_REQ;
         default:  nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy              = 1'b0;
      mem.mem_req_valid = 1'b0;
      mem.mem_req_write = 1'b0;
      mem.mem_req_addr  = '0;
      case (state)
         S_W_REQ: begin
            busy              = 1'b1;
            mem.mem_req_valid = 1'b1;
            mem.mem_req_addr  = 32'(W_BASE) + 32'(idx);
         end
         S_B_REQ: begin
            busy              = 1'b1;
            mem.mem_req_valid = 1'b1;
            mem.mem_req_addr  = 32'(B_BASE) + 32'(idx);
         end
         S_W_WAIT, S_B_WAIT: busy = 1'b1;
         default: ;
      endcase
   end

   // done rises one cycle after entering S_DONE and drops on the start that leaves it
   always_ff @(posedge clk) begin
      if (rst) begin
         idx  <= '0;
         done <= 1'b0;
      end else begin
         if (accept) begin
            idx  <= '0;
            done <= 1'b0;
         end else if (state == S_DONE) begin
            done <= 1'b1;
         end
         if (state == S_W_WAIT && mem.mem_resp_valid)
            idx <= w_last ? '0 : idx + IW'(1);
         if (state == S_B_WAIT && mem.mem_resp_valid && !b_last)
            idx <= idx + IW'(1);
      end
   end

   // Arrays are deliberately not reset; responses outside the wait states are dropped.
   always_ff @(posedge clk) begin
      if (!rst && mem.mem_resp_valid) begin
         if (state == S_W_WAIT) weight_mem[idx[WA-1:0]] <= mem.mem_resp_data;
         if (state == S_B_WAIT) bias_mem[idx[BA-1:0]]   <= mem.mem_resp_data;
      end
   end

   assign w_rd_data = weight_mem[w_rd_addr];
   assign b_rd_data = bias_mem[b_rd_addr];

endmodule

// File: tb/tb_conv_weight_bias_loader.sv
// Directed-plus-random bench for conv_weight_bias_loader against a variable-latency memory model.
module tb_conv_weight_bias_loader;
   localparam int W_COUNT = 756;
   localparam int B_COUNT = 28;
   localparam int W_BASE  = 0;
   localparam int B_BASE  = W_COUNT;
   localparam int TOTAL   = W_COUNT + B_COUNT;

   logic              clk = 1'b0;
   logic              rst, start, done, busy;
   logic [9:0]        w_rd_addr;
   logic [4:0]        b_rd_addr;
   logic signed [7:0] w_rd_data, b_rd_data;

   conv_weight_bias_loader_if bus ();

   conv_weight_bias_loader #(
      .W_COUNT(W_COUNT), .B_COUNT(B_COUNT), .W_BASE(W_BASE), .B_BASE(B_BASE)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy), .mem(bus),
      .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Memory model: response becomes visible lat edges after the request edge.
   logic [7:0]  mem [0:TOTAL-1];
   int          lat = 1;
   int          m_cnt = 0;
   logic        m_valid = 1'b0;
   logic [7:0]  m_data = '0;
   logic [31:0] m_addr = '0;
   logic        spur_valid = 1'b0;
   logic [7:0]  spur_data = '0;

   always @(posedge clk) begin
      m_valid <= 1'b0;
      if (bus.mem_req_valid) begin
         if (lat == 1) begin
            m_valid <= 1'b1;
            m_data  <= mem[bus.mem_req_addr[9:0]];
         end else begin
            m_cnt  <= lat - 1;
            m_addr <= bus.mem_req_addr;
         end
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_valid <= 1'b1;
            m_data  <= mem[m_addr[9:0]];
         end
      end
   end

   assign bus.mem_resp_valid = m_valid | spur_valid;
   assign bus.mem_resp_data  = spur_valid ? spur_data : m_data;

   // Request trace monitor
   int          req_cnt = 0, addr_err = 0, wr_err = 0, ovl_err = 0;
   logic        outst = 1'b0;
   logic [31:0] exp_addr = '0;

   always @(posedge clk) begin
      if (bus.mem_req_write !== 1'b0) wr_err++;
      if (rst) outst = 1'b0;
      else begin
         if (m_valid) outst = 1'b0;
         if (bus.mem_req_valid) begin
            if (outst) ovl_err++;
            if (bus.mem_req_addr !== exp_addr) addr_err++;
            exp_addr++;
            req_cnt++;
            outst = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_arrays(input string tag);
      int err = 0;
      for (int i = 0; i < W_COUNT; i++)
         if ($unsigned(dut.weight_mem[i]) !== mem[W_BASE + i]) err++;
      for (int j = 0; j < B_COUNT; j++)
         if ($unsigned(dut.bias_mem[j]) !== mem[B_BASE + j]) err++;
      chk({tag, "_arrays"}, err, 0);
   endtask

   task automatic chk_trace(input string tag);
      chk({tag, "_req_cnt"}, req_cnt, TOTAL);
      chk({tag, "_addr_err"}, addr_err, 0);
      chk({tag, "_wr_err"}, wr_err, 0);
      chk({tag, "_overlap"}, ovl_err, 0);
   endtask

   task automatic fill_random();
      for (int a = 0; a < TOTAL; a++) mem[a] = 8'($urandom);
   endtask

   // Pulses start, optionally re-pulses it at cycle restart_at, returns edge count until done.
   task automatic run_load(input string tag, input int restart_at, output int cyc);
      req_cnt = 0; addr_err = 0; wr_err = 0; ovl_err = 0; exp_addr = 32'(W_BASE);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 chk({tag, "_done_drop"}, done, 0);
      @(negedge clk) start = 1'b0;
      cyc = 0;
      while (cyc < 20000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done) break;
         @(negedge clk) start = (cyc == restart_at);
      end
      start = 1'b0;
   endtask

   initial begin
      int cyc, err;
      rst = 1'b1; start = 1'b0; w_rd_addr = '0; b_rd_addr = '0;
      for (int a = 0; a < TOTAL; a++) mem[a] = a[7:0];

      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req", bus.mem_req_valid, 0);
      chk("rst_addr", bus.mem_req_addr, 0);
      @(negedge clk) rst = 1'b0;

      // Latency 1, address-pattern memory
      run_load("l1", -1, cyc);
      chk("l1_cycles", cyc, 2 * TOTAL + 1);
      chk("l1_busy_after", busy, 0);
      chk("w5", dut.weight_mem[5], 5);
      chk("w255", dut.weight_mem[255], -1);
      chk("w755", dut.weight_mem[755], -13);
      chk("b0", dut.bias_mem[0], -12);
      chk("b27", dut.bias_mem[27], 15);
      chk_arrays("l1");
      chk_trace("l1");

      // Spurious response while idle must not store
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      spur_valid = 1'b1; spur_data = 8'h7F;
      @(negedge clk) spur_valid = 1'b0;
      @(negedge clk);
      chk("spur_w0", dut.weight_mem[0], 0);
      chk("spur_busy", busy, 0);
      err = 0;
      for (int k = 0; k < 16; k++) begin
         w_rd_addr = 10'($urandom_range(W_COUNT - 1));
         b_rd_addr = 5'($urandom_range(B_COUNT - 1));
         #1;
         if (8'(w_rd_data) !== mem[W_BASE + int'(w_rd_addr)]) err++;
         if (8'(b_rd_data) !== mem[B_BASE + int'(b_rd_addr)]) err++;
      end
      chk("readback", err, 0);

      // Latency 3: same contents, slower
      lat = 3;
      run_load("l3", -1, cyc);
      chk("l3_cycles", cyc, 4 * TOTAL + 1);
      chk_arrays("l3");
      chk_trace("l3");

      // Start re-pulsed mid-load is ignored
      lat = 1;
      fill_random();
      run_load("rs", 100, cyc);
      chk("rs_cycles", cyc, 2 * TOTAL + 1);
      chk_arrays("rs");
      chk_trace("rs");

      // Restart from DONE with new contents
      fill_random();
      run_load("re", -1, cyc);
      chk("re_cycles", cyc, 2 * TOTAL + 1);
      chk_arrays("re");

      // Reset during bias phase
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2 * W_COUNT + 20) @(negedge clk);
      chk("mid_busy_pre", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_done", done, 0);
      chk("mid_busy", busy, 0);
      chk("mid_req", bus.mem_req_valid, 0);
      @(negedge clk) rst = 1'b0;
      req_cnt = 0;
      repeat (10) @(negedge clk);
      chk("mid_no_req", req_cnt, 0);
      fill_random();
      run_load("ar", -1, cyc);
      chk("ar_cycles", cyc, 2 * TOTAL + 1);
      chk_arrays("ar");
      chk_trace("ar");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
